// File: rtl/smag_accum.sv
// smag_accum: accumulates a run of 16-bit sign-magnitude products into a
// sign-magnitude result through an IDLE -> ACC -> DONE handshake FSM.
// Ports: clk, rst (sync, active high); start/len open a run (IDLE only);
//   in_valid/in_data/in_ready carry products while in ACC;
//   out_valid/out_ready/out_data hand off the result held in DONE;
//   busy is high in ACC and DONE; ovf is the sticky per-run range flag.
// Config: define SMAG_ACCUM_SAT_EN to clamp the accumulator to
//   +/-(2^MAG_W-1); when undefined it wraps modulo 2^(MAG_W+1).
module smag_accum #(
  parameter int MAG_W = 19
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [7:0]     len,
  input  logic           in_valid,
  input  logic [15:0]    in_data,
  output logic           in_ready,
  output logic           busy,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [MAG_W:0] out_data,
  output logic           ovf
);

  localparam int AW = MAG_W + 2;
  localparam int SW = MAG_W + 3;

  localparam logic signed [SW-1:0] LIM_P =
    {{(SW-MAG_W){1'b0}}, {MAG_W{1'b1}}};
  localparam logic signed [SW-1:0] LIM_N = -LIM_P;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] acc_d;
  logic [7:0]           cnt_q;
  logic [MAG_W:0]       res_q;
  logic [MAG_W:0]       res_d;
  logic                 ovf_q;
  logic                 in_ready_q;
  logic                 busy_q;
  logic                 out_valid_q;

  logic                 xfer;
  logic                 last;
  logic                 ovf_hit;
  logic signed [SW-1:0] mag_s;
  logic signed [SW-1:0] prod_s;
  logic signed [SW-1:0] sum_s;
  logic signed [AW-1:0] abs_d;
  logic                 unused_abs;

  assign xfer = in_ready_q & in_valid;
  assign last = (cnt_q == 8'd1);

  // Negative zero needs no special case: -0 is 0.
  always_comb begin
    mag_s  = {{(SW-15){1'b0}}, in_data[14:0]};
    prod_s = in_data[15] ? -mag_s : mag_s;
    sum_s  = {{(SW-AW){acc_q[AW-1]}}, acc_q} + prod_s;
    ovf_hit = (sum_s > LIM_P) || (sum_s < LIM_N);
`ifdef SMAG_ACCUM_SAT_EN
    if (sum_s > LIM_P) begin
      acc_d = LIM_P[AW-1:0];
    end else if (sum_s < LIM_N) begin
      acc_d = LIM_N[AW-1:0];
    end else begin
      acc_d = sum_s[AW-1:0];
    end
`else
    // Keep MAG_W+1 bits and sign-extend: -2^MAG_W survives and
    // shows up as sign 1, magnitude 0.
    acc_d = {sum_s[MAG_W], sum_s[MAG_W:0]};
`endif
    abs_d = acc_d[AW-1] ? -acc_d : acc_d;
    res_d = {acc_d[AW-1], abs_d[MAG_W-1:0]};
  end

  assign unused_abs = ^abs_d[AW-1:MAG_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            res_q  <= '0;
            busy_q <= 1'b1;
            if (len == 8'd0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q    <= ACC;
              cnt_q      <= len;
              in_ready_q <= 1'b1;
            end
          end
        end
        ACC: begin
          if (xfer) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - 8'd1;
            ovf_q <= ovf_q | ovf_hit;
            if (last) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              res_q       <= res_d;
            end
          end
        end
        DONE: begin
          // start is deliberately not looked at here.
          if (out_ready) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = res_q;
  assign ovf       = ovf_q;

endmodule
